// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
//   4-to-1 single-bit multiplexer with a combinational output and an optional
//   registered copy of the same selection, so the block can sit directly on a
//   pipeline boundary.
//
// Parameters
//   REG_OUT : 1 = dout is the registered selection (1 clock latency)
//             0 = dout mirrors dout_comb (the flop is still built, not used)
//   RST_VAL : value forced into the output flop while rst_n is low
//
// Ports
//   clk       in   rising-edge clock for the output flop
//   rst_n     in   asynchronous, active-low reset (flop only)
//   din[3:0]  in   data lanes din[0]..din[3]
//   sel[1:0]  in   lane select, unsigned 0..3
//   dout_comb out  din[sel], zero latency, unaffected by reset
//   dout      out  registered or combinational selection per REG_OUT
//
// Interface semantics: there is no handshake. Every rising clk edge (outside
// reset) captures the current selection unconditionally; no enable exists.
// -----------------------------------------------------------------------------
module mux_4x1 #(
   parameter bit   REG_OUT = 1'b1,
   parameter logic RST_VAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] din,
   input  logic [1:0] sel,
   output logic       dout_comb,
   output logic       dout
);

   logic [3:0] lane_hit;   // one-hot decode of sel
   logic       sop_sel;    // sum-of-products selection
   logic       all_ones;
   logic       any_one;
   logic       dout_q;

   // Sum-of-products form keeps X handling tight: an unknown in an
   // unselected lane is ANDed with a known 0 and drops out, while an unknown
   // select bit pollutes every candidate term.
   always_comb begin
      lane_hit[0] = ~sel[1] & ~sel[0];
      lane_hit[1] = ~sel[1] &  sel[0];
      lane_hit[2] =  sel[1] & ~sel[0];
      lane_hit[3] =  sel[1] &  sel[0];
      sop_sel     = |(lane_hit & din);
   end

   // When all four lanes agree the select is irrelevant: force the common
   // value so an unknown select still resolves. Functionally this is the
   // identity on known inputs (all ones -> 1, all zeros -> 0, else sop_sel).
   always_comb begin
      all_ones  = &din;
      any_one   = |din;
      dout_comb = all_ones | (sop_sel & any_one);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= RST_VAL;
      end else begin
         dout_q <= dout_comb;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         assign dout = dout_q;
      end else begin : g_comb_out
         assign dout = dout_comb;
      end
   endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1
//   Bench for mux_4x1. Two instances share the same din/sel: one with the
//   registered output (REG_OUT=1) and one with the combinational output
//   (REG_OUT=0). Expected values come from a lane-shift reference model and a
//   one-entry pipeline model of the output register.
// -----------------------------------------------------------------------------
module tb_mux_4x1;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic [1:0] sel;
  logic       dout_comb;
  logic       dout;
  logic       dout_comb_c;
  logic       dout_c;

  int total;
  int bad;

  logic       exp_reg;     // model of the registered output
  logic       four_state;  // simulator keeps X values
  logic       probe;

  mux_4x1 #(.REG_OUT(1'b1), .RST_VAL(1'b0)) u_dut_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .dout_comb (dout_comb),
    .dout      (dout)
  );

  mux_4x1 #(.REG_OUT(1'b0), .RST_VAL(1'b0)) u_dut_comb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .dout_comb (dout_comb_c),
    .dout      (dout_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected lane is bit 0 of din shifted right by sel.
  function automatic logic ref_mux(input logic [3:0] d, input logic [1:0] s);
    logic [3:0] shifted;
    shifted = d >> s;
    return shifted[0];
  endfunction

  // Register model: one-cycle delayed copy of the reference, reset to 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_reg <= 1'b0;
    else        exp_reg <= ref_mux(din, sel);
  end

  // drive at the falling edge so inputs are stable around the rising edge
  task automatic drive(input logic [3:0] d, input logic [1:0] s);
    @(negedge clk);
    din = d;
    sel = s;
    #1;
  endtask

  task automatic test_reset;
    // rst_n is low from time 0; no clock edge has happened yet
    #2;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_clk dout=%b want=0", dout);
    end
    @(posedge clk); #1;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold dout=%b want=0", dout);
    end
    // comb path ignores reset
    total++;
    if (dout_comb !== ref_mux(din, sel)) begin
      bad++;
      $display("FAIL reset_comb dout_comb=%b want=%b", dout_comb, ref_mux(din, sel));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_sweep;
    for (int s = 0; s < 4; s++) begin
      for (int k = 1; k <= 16; k++) begin
        drive(4'(k % 16), 2'(s));
        total++;
        if (dout_comb !== ref_mux(din, sel)) begin
          bad++;
          $display("FAIL sweep_comb sel=%0d din=%b dout_comb=%b want=%b",
                   s, din, dout_comb, ref_mux(din, sel));
        end
        total++;
        if (dout !== exp_reg) begin
          bad++;
          $display("FAIL sweep_reg sel=%0d din=%b dout=%b want=%b",
                   s, din, dout, exp_reg);
        end
      end
    end
    // spot values called out directly
    drive(4'b0101, 2'd0);
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL spot_0101_s0 dout_comb=%b want=1", dout_comb);
    end
    drive(4'b0010, 2'd1);
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL spot_0010_s1 dout_comb=%b want=1", dout_comb);
    end
    drive(4'b1011, 2'd2);
    total++;
    if (dout_comb !== 1'b0) begin
      bad++; $display("FAIL spot_1011_s2 dout_comb=%b want=0", dout_comb);
    end
    drive(4'b1000, 2'd3);
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL spot_1000_s3 dout_comb=%b want=1", dout_comb);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      total++;
      if (dout_comb !== ref_mux(din, sel)) begin
        bad++;
        $display("FAIL rand_comb din=%b sel=%0d dout_comb=%b want=%b",
                 din, sel, dout_comb, ref_mux(din, sel));
      end
      total++;
      if (dout !== exp_reg) begin
        bad++;
        $display("FAIL rand_reg din=%b sel=%0d dout=%b want=%b", din, sel, dout, exp_reg);
      end
      total++;
      if (dout_c !== ref_mux(din, sel)) begin
        bad++;
        $display("FAIL rand_dout_c din=%b sel=%0d dout=%b want=%b",
                 din, sel, dout_c, ref_mux(din, sel));
      end
    end
  endtask

  task automatic test_unused_lanes;
    logic [3:0] d;
    logic       held;
    for (int s = 0; s < 4; s++) begin
      d = 4'($urandom_range(0, 15));
      drive(d, 2'(s));
      held = ref_mux(d, 2'(s));
      for (int b = 0; b < 4; b++) begin
        if (b != s) begin
          din[b] = ~din[b];
          #1;
          total++;
          if (dout_comb !== held) begin
            bad++;
            $display("FAIL unused_lane sel=%0d flip=%0d dout_comb=%b want=%b",
                     s, b, dout_comb, held);
          end
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    drive(4'b0001, 2'd0);
    // change both at once, between clock edges
    #1;
    din = 4'b1000;
    sel = 2'd3;
    #1;
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL simul_change dout_comb=%b want=1", dout_comb);
    end
    din = 4'b0111;
    sel = 2'd3;
    #1;
    total++;
    if (dout_comb !== 1'b0) begin
      bad++; $display("FAIL simul_change2 dout_comb=%b want=0", dout_comb);
    end
  endtask

  task automatic test_mid_reset;
    drive(4'b1111, 2'd2);
    @(posedge clk); #2;
    total++;
    if (dout !== 1'b1) begin
      bad++; $display("FAIL pre_reset dout=%b want=1", dout);
    end
    // assert between edges; the flop must clear with no clock
    rst_n = 1'b0;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++; $display("FAIL async_reset dout=%b want=0", dout);
    end
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL reset_comb_free dout_comb=%b want=1", dout_comb);
    end
    total++;
    if (dout_c !== 1'b1) begin
      bad++; $display("FAIL reset_dout_c dout=%b want=1", dout_c);
    end
    @(posedge clk); #1;
    total++;
    if (dout !== 1'b0) begin
      bad++; $display("FAIL reset_held dout=%b want=0", dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++; $display("FAIL post_release dout=%b want=0", dout);
    end
    @(posedge clk); #1;
    total++;
    if (dout !== 1'b1) begin
      bad++; $display("FAIL first_capture dout=%b want=1", dout);
    end
  endtask

  task automatic test_comb_build;
    drive(4'b0100, 2'd1);
    total++;
    if (dout_c !== 1'b0) begin
      bad++; $display("FAIL comb_build_s1 dout=%b want=0", dout_c);
    end
    #1;
    sel = 2'd2;   // no clock edge between these samples
    #1;
    total++;
    if (dout_c !== 1'b1) begin
      bad++; $display("FAIL comb_build_s2 dout=%b want=1", dout_c);
    end
  endtask

  task automatic test_unknowns;
    drive(4'bxxxx, 2'd1);
    total++;
    if (dout_comb !== 1'bx) begin
      bad++; $display("FAIL x_selected dout_comb=%b want=x", dout_comb);
    end
    drive(4'bx001, 2'd0);
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL x_unselected dout_comb=%b want=1", dout_comb);
    end
    drive(4'b1111, 2'bx1);
    total++;
    if (dout_comb !== 1'b1) begin
      bad++; $display("FAIL xsel_equal dout_comb=%b want=1", dout_comb);
    end
    drive(4'b1010, 2'bx1);
    total++;
    if (dout_comb !== 1'bx) begin
      bad++; $display("FAIL xsel_mixed dout_comb=%b want=x", dout_comb);
    end
    @(posedge clk); #1;
    total++;
    if (dout !== 1'bx) begin
      bad++; $display("FAIL x_captured dout=%b want=x", dout);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    din   = 4'b0110;
    sel   = 2'd1;
    probe = 1'bx;
    #0;
    four_state = (probe === 1'bx);

    test_reset();
    test_sweep();
    test_random();
    test_unused_lanes();
    test_simultaneous();
    test_mid_reset();
    test_comb_build();
    if (four_state) test_unknowns();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
